// File: rtl/wb_check_pkg.sv
// rtl/wb_check_pkg.sv - shared types and constants for the writeback scoreboard
package wb_check_pkg;

    localparam int PC_W_P   = 36;
    localparam int REG_W_P  = 5;
    localparam int DATA_W_P = 36;

    // Compare mask for lil, which only writes the low 18 bits.
    localparam logic [DATA_W_P-1:0] LIL_MASK = 36'h0_0003_FFFF;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_REG       = 3'd1,
        ERR_DATA      = 3'd2,
        ERR_UNDERFLOW = 3'd3,
        ERR_TIMEOUT   = 3'd4
    } err_code_t;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [PC_W_P-1:0]   pc;
        logic [REG_W_P-1:0]  dst_reg;
        logic [DATA_W_P-1:0] data;
        logic [DATA_W_P-1:0] mask;
    } exp_rec_t;

endpackage

// File: rtl/wb_rec_fifo.sv
// rtl/wb_rec_fifo.sv - circular FIFO of expected retirement records
module wb_rec_fifo
    import wb_check_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  exp_rec_t               wr_rec_i,
    output exp_rec_t               head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    exp_rec_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    // Storage needs no reset: reset only discards the pointers.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wr_rec_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - in-order writeback checker; WB_SCOREBOARD_TIMEOUT_EN adds an idle watchdog
module wb_scoreboard
    import wb_check_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PC_W    = 36,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 36,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   exp_valid,
    output logic                   exp_ready,
    input  logic [PC_W-1:0]        exp_pc,
    input  logic [REG_W-1:0]       exp_reg,
    input  logic [DATA_W-1:0]      exp_data,
    input  logic [DATA_W-1:0]      exp_mask,
    input  logic                   act_valid,
    input  logic [REG_W-1:0]       act_reg,
    input  logic [DATA_W-1:0]      act_data,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [31:0]            pass_count,
    output logic                   halted,
    output logic [2:0]             err_code,
    output logic [PC_W-1:0]        err_pc,
    output logic [DATA_W-1:0]      err_exp_data,
    output logic [DATA_W-1:0]      err_act_data
);

    state_t            state_q, state_d;
    err_code_t         err_code_q, err_code_d, err_sel;
    logic [31:0]       pass_q, pass_d;
    logic [PC_W-1:0]   err_pc_q, err_pc_d, err_pc_n;
    logic [DATA_W-1:0] err_exp_q, err_exp_d, err_exp_n;
    logic [DATA_W-1:0] err_act_q, err_act_d, err_act_n;
    exp_rec_t          wr_rec, head;
    logic              full, empty, push, pop, check, err_hit, timeout_hit;

    assign wr_rec = '{pc: exp_pc, dst_reg: exp_reg, data: exp_data, mask: exp_mask};
    assign push   = exp_valid && exp_ready;
    assign check  = (state_q == S_RUN) && act_valid;
    // Every checked write with a head record consumes it, pass or fail.
    assign pop    = check && !empty;

    wb_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (clear),
        .push_i   (push),
        .pop_i    (pop),
        .wr_rec_i (wr_rec),
        .head_o   (head),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (occupancy)
    );

`ifdef WB_SCOREBOARD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_idle;

    assign wd_idle     = (state_q == S_RUN) && !empty && !act_valid;
    // Fires on the edge that would take the counter to TIMEOUT.
    assign timeout_hit = wd_idle && (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        wd_d = wd_q;
        if (clear || act_valid || empty) wd_d = '0;
        else if (wd_idle)                wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        err_hit   = 1'b0;
        err_sel   = ERR_NONE;
        err_pc_n  = head.pc;
        err_exp_n = head.data;
        err_act_n = act_data;
        if (check) begin
            if (empty) begin
                err_hit   = 1'b1;
                err_sel   = ERR_UNDERFLOW;
                err_pc_n  = '0;
                err_exp_n = '0;
            end else if (head.dst_reg != act_reg) begin
                err_hit = 1'b1;
                err_sel = ERR_REG;
            end else if (((act_data ^ head.data) & head.mask) != '0) begin
                err_hit = 1'b1;
                err_sel = ERR_DATA;
            end
        end else if (timeout_hit) begin
            err_hit   = 1'b1;
            err_sel   = ERR_TIMEOUT;
            err_act_n = '0;
        end
    end

    always_comb begin
        pass_d     = pass_q;
        err_code_d = err_code_q;
        err_pc_d   = err_pc_q;
        err_exp_d  = err_exp_q;
        err_act_d  = err_act_q;
        if (clear) begin
            pass_d     = '0;
            err_code_d = ERR_NONE;
            err_pc_d   = '0;
            err_exp_d  = '0;
            err_act_d  = '0;
        end else if (err_hit) begin
            err_code_d = err_sel;
            err_pc_d   = err_pc_n;
            err_exp_d  = err_exp_n;
            err_act_d  = err_act_n;
        end else if (pop && (pass_q != 32'hFFFF_FFFF)) begin
            pass_d = pass_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q     <= '0;
            err_code_q <= ERR_NONE;
            err_pc_q   <= '0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
        end else begin
            pass_q     <= pass_d;
            err_code_q <= err_code_d;
            err_pc_q   <= err_pc_d;
            err_exp_q  <= err_exp_d;
            err_act_q  <= err_act_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear)                               state_d = S_RUN;
        else if (state_q == S_RUN && err_hit)    state_d = S_HALT;
    end

    always_comb begin
        exp_ready = !full && (state_q == S_RUN);
        halted    = (state_q == S_HALT);
    end

    assign pass_count   = pass_q;
    assign err_code     = err_code_q;
    assign err_pc       = err_pc_q;
    assign err_exp_data = err_exp_q;
    assign err_act_data = err_act_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// tb/tb_wb_scoreboard.sv - directed bench with a queue-based reference model for wb_scoreboard
module tb_wb_scoreboard;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;
    localparam logic [35:0] ONES = 36'hF_FFFF_FFFF;
    localparam logic [35:0] LIL  = 36'h0_0003_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        exp_valid, act_valid, clear;
    logic        exp_ready, halted;
    logic [35:0] exp_pc, exp_data, exp_mask, act_data;
    logic [4:0]  exp_reg, act_reg, occupancy;
    logic [31:0] pass_count;
    logic [2:0]  err_code;
    logic [35:0] err_pc, err_exp_data, err_act_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [35:0] pc;
        logic [4:0]  rd;
        logic [35:0] data;
        logic [35:0] mask;
    } rec_t;

    rec_t        mq[$];
    logic [31:0] m_pass;
    logic        m_halt;
    logic [2:0]  m_err;
    logic [35:0] m_pc, m_exp, m_act;
    int          m_idle;

    wb_scoreboard dut (
        .clk(clk), .rst(rst),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_pc(exp_pc),
        .exp_reg(exp_reg), .exp_data(exp_data), .exp_mask(exp_mask),
        .act_valid(act_valid), .act_reg(act_reg), .act_data(act_data),
        .clear(clear), .occupancy(occupancy), .pass_count(pass_count),
        .halted(halted), .err_code(err_code), .err_pc(err_pc),
        .err_exp_data(err_exp_data), .err_act_data(err_act_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_pass = 0; m_halt = 0; m_err = 0;
        m_pc = 0; m_exp = 0; m_act = 0; m_idle = 0;
    endtask

    task automatic m_fail(input logic [2:0] code, input logic [35:0] pc,
                          input logic [35:0] ed, input logic [35:0] ad);
        m_halt = 1; m_err = code; m_pc = pc; m_exp = ed; m_act = ad;
    endtask

    // Retirement rules applied to the inputs seen at one clock edge.
    task automatic m_step();
        int   sz;
        bit   can_push;
        rec_t h;
        if (rst || clear) begin
            m_reset();
            return;
        end
        if (m_halt) return;
        sz       = mq.size();
        can_push = (sz < DEPTH);
        if (act_valid) begin
            m_idle = 0;
            if (sz == 0) m_fail(3'd3, 36'd0, 36'd0, act_data);
            else begin
                h = mq.pop_front();
                if (h.rd != act_reg)                          m_fail(3'd1, h.pc, h.data, act_data);
                else if (((act_data ^ h.data) & h.mask) != 0) m_fail(3'd2, h.pc, h.data, act_data);
                else if (m_pass != 32'hFFFF_FFFF)             m_pass++;
            end
        end
`ifdef WB_SCOREBOARD_TIMEOUT_EN
        else if (sz == 0) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle == TIMEOUT) m_fail(3'd4, mq[0].pc, mq[0].data, 36'd0);
        end
`endif
        if (exp_valid && can_push) begin
            h.pc = exp_pc; h.rd = exp_reg; h.data = exp_data; h.mask = exp_mask;
            mq.push_back(h);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("occupancy",    64'(occupancy),    64'(mq.size()));
            chk("pass_count",   64'(pass_count),   64'(m_pass));
            chk("halted",       64'(halted),       64'(m_halt));
            chk("exp_ready",    64'(exp_ready),    64'(mq.size() < DEPTH && !m_halt));
            chk("err_code",     64'(err_code),     64'(m_err));
            chk("err_pc",       64'(err_pc),       64'(m_pc));
            chk("err_exp_data", 64'(err_exp_data), 64'(m_exp));
            chk("err_act_data", 64'(err_act_data), 64'(m_act));
        end
    end

    task automatic tick();
        @(posedge clk);
        m_step();
        #2;
    endtask

    task automatic drive(input bit ev, input logic [35:0] pc, input logic [4:0] rd,
                         input logic [35:0] d, input logic [35:0] m,
                         input bit av, input logic [4:0] ar, input logic [35:0] ad);
        exp_valid = ev; exp_pc = pc; exp_reg = rd; exp_data = d; exp_mask = m;
        act_valid = av; act_reg = ar; act_data = ad;
        tick();
        exp_valid = 0; act_valid = 0;
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    initial begin
        rst = 1; clear = 0; exp_valid = 0; act_valid = 0;
        exp_pc = 0; exp_reg = 0; exp_data = 0; exp_mask = 0; act_reg = 0; act_data = 0;
        m_reset();
        repeat (3) tick();
        rst = 0;
        tick();
        chk("rst_exp_ready", 64'(exp_ready), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_err_code",  64'(err_code),  64'd0);

        drive(1, 36'h10, 5'd3, 36'h0_0000_00AB, ONES, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 5'd3, 36'h0_0000_00AB);
        chk("match_pass",  64'(pass_count), 64'd1);
        chk("match_err",   64'(err_code),   64'd0);
        chk("match_occ",   64'(occupancy),  64'd0);

        drive(1, 36'h14, 5'd4, 36'h5, ONES, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 5'd5, 36'h5);
        chk("regmis_code",   64'(err_code),  64'd1);
        chk("regmis_pc",     64'(err_pc),    64'h14);
        chk("regmis_halted", 64'(halted),    64'd1);
        chk("regmis_ready",  64'(exp_ready), 64'd0);
        drive(1, 36'h40, 5'd1, 36'h1, ONES, 0, 0, 0);
        chk("halt_no_push",  64'(occupancy), 64'd0);
        do_clear();

        drive(1, 36'h18, 5'd2, 36'hF_0001_2345, LIL, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 5'd2, 36'h0_0001_2345);
        chk("lil_pass",     64'(pass_count),   64'd1);
        drive(1, 36'h1C, 5'd2, 36'hF_0001_2345, LIL, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 5'd2, 36'h0_0001_2346);
        chk("lil_code",     64'(err_code),     64'd2);
        chk("lil_act_data", 64'(err_act_data), 64'h0_0001_2346);
        chk("lil_exp_data", 64'(err_exp_data), 64'hF_0001_2345);
        do_clear();

        for (int i = 0; i < DEPTH; i++)
            drive(1, 36'h100 + 36'(4 * i), 5'(i), 36'(3 * i), ONES, 0, 0, 0);
        chk("full_ready", 64'(exp_ready), 64'd0);
        chk("full_occ",   64'(occupancy), 64'd16);
        drive(1, 36'h200, 5'd20, 36'd77, ONES, 1, 5'd0, 36'd0);
        chk("full_refused_occ", 64'(occupancy),  64'd15);
        drive(1, 36'h200, 5'd20, 36'd77, ONES, 1, 5'd1, 36'd3);
        chk("pushpop_occ",  64'(occupancy),  64'd15);
        chk("pushpop_pass", 64'(pass_count), 64'd2);
        do_clear();

        drive(1, 36'h300, 5'd7, 36'h99, ONES, 1, 5'd7, 36'h42);
        chk("under_code", 64'(err_code),     64'd3);
        chk("under_pc",   64'(err_pc),       64'd0);
        chk("under_act",  64'(err_act_data), 64'h42);
        chk("under_occ",  64'(occupancy),    64'd1);
        do_clear();
        chk("clr_code",   64'(err_code),   64'd0);
        chk("clr_halted", 64'(halted),     64'd0);
        chk("clr_pass",   64'(pass_count), 64'd0);

        drive(1, 36'h400, 5'd9, 36'h123, ONES, 0, 0, 0);
`ifdef WB_SCOREBOARD_TIMEOUT_EN
        repeat (TIMEOUT - 1) tick();
        chk("wd_early", 64'(err_code), 64'd0);
        tick();
        chk("wd_code", 64'(err_code),     64'd4);
        chk("wd_pc",   64'(err_pc),       64'h400);
        chk("wd_exp",  64'(err_exp_data), 64'h123);
        chk("wd_act",  64'(err_act_data), 64'd0);
`else
        repeat (200) tick();
        chk("nowd_code", 64'(err_code),  64'd0);
        chk("nowd_occ",  64'(occupancy), 64'd1);
`endif
        do_clear();

        drive(1, 36'h500, 5'd1, 36'h1, ONES, 0, 0, 0);
        drive(1, 36'h504, 5'd2, 36'h2, ONES, 0, 0, 0);
        #1 rst = 1;
        m_reset();
        #1;
        chk("async_rst_occ",  64'(occupancy), 64'd0);
        chk("async_rst_code", 64'(err_code),  64'd0);
        tick();
        rst = 0;
        repeat (2) tick();
        chk("post_rst_ready", 64'(exp_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
